// File: rtl/dct_pkg.sv
// Shared definitions for the 8-point approximate DCT engine.
//   state_e  : batch/address FSM states of dct8_engine
//   bf_op_e  : per-cycle operation selected for the butterfly register file
//   NPTS     : points per vector
//   sat_shift: arithmetic right shift followed by clamp (or plain wrap);
//              the caller keeps the low data_w bits of the result.
package dct_pkg;

  localparam int NPTS = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    S1,
    S2,
    S3,
    WRITE,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    BF_HOLD,
    BF_LOAD,
    BF_S1,
    BF_S2,
    BF_S3,
    BF_SHIFT
  } bf_op_e;

  // Shift first, then clamp: the clamp bounds are the data_w signed range.
  // With sat=0 the shifted value is returned as-is and the caller's
  // truncation to data_w bits gives two's-complement wrap.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] value,
    input int                 shift,
    input logic               sat,
    input int                 data_w
  );
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = value >>> shift;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sat) begin
      if (sh > hi) begin
        sh = hi;
      end else if (sh < lo) begin
        sh = lo;
      end
    end
    return sh;
  endfunction

endpackage

// File: rtl/dct8_butterfly.sv
// Eight-register butterfly datapath for the approximate 8-point DCT.
// The same eight registers hold, in turn, the input samples, the S1 and S2
// partial sums and finally the eight results, so no extra storage is needed.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears all registers)
//   op         : operation for this cycle (hold/load/S1/S2/S3/shift-out)
//   din        : sample shifted into the top register on BF_LOAD
//   dout       : register 0 (result k during the k-th shift-out cycle)
module dct8_butterfly
  import dct_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  bf_op_e                   op,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W+2:0] dout
);

  localparam int IW = DATA_W + 3;

  logic signed [IW-1:0] v   [NPTS];
  logic signed [IW-1:0] v_n [NPTS];

  always_comb begin
    for (int k = 0; k < NPTS; k++) begin
      v_n[k] = v[k];
    end
    case (op)
      // Samples arrive in order x0..x7; shifting down leaves x0 in reg 0.
      BF_LOAD: begin
        for (int k = 0; k < NPTS - 1; k++) begin
          v_n[k] = v[k + 1];
        end
        v_n[NPTS-1] = {{3{din[DATA_W-1]}}, din};
      end
      BF_S1: begin
        v_n[0] = v[0] + v[7];
        v_n[1] = v[1] + v[6];
        v_n[2] = v[2] + v[5];
        v_n[3] = v[3] + v[4];
        v_n[4] = v[4] - v[3];
        v_n[5] = v[5] - v[2];
        v_n[6] = v[6] - v[1];
        v_n[7] = v[7] - v[0];
      end
      // Odd half (a4..a7) passes through unchanged as b4..b7.
      BF_S2: begin
        v_n[0] = v[0] + v[3];
        v_n[1] = v[1] + v[2];
        v_n[2] = v[2] - v[1];
        v_n[3] = v[3] - v[0];
      end
      BF_S3: begin
        v_n[0] = v[0] + v[1];
        v_n[1] = -(v[6] + v[7]);
        v_n[2] = -v[3];
        v_n[3] = v[5];
        v_n[4] = v[0] - v[1];
        v_n[5] = v[6] - v[7];
        v_n[6] = v[2];
        v_n[7] = v[4];
      end
      BF_SHIFT: begin
        for (int k = 0; k < NPTS - 1; k++) begin
          v_n[k] = v[k + 1];
        end
        v_n[NPTS-1] = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NPTS; k++) begin
        v[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NPTS; k++) begin
        v[k] <= v_n[k];
      end
    end
  end

  assign dout = v[0];

endmodule

// File: rtl/dct8_engine.sv
// Batch 8-point approximate DCT engine driving a single-port block RAM.
// One command reads up to 15 vectors of 8 strided samples, transforms each
// through dct8_butterfly and writes the 8 scaled results back.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   start           : command strobe, sampled only while idle
//   busy            : high while a batch with nvec>0 is in progress
//   done            : one-cycle pulse when the batch has finished
//   rstart, wstart  : first read / write address of vector 0
//   stride          : address step between samples of a vector
//   vec_step        : step added to both bases between vectors
//   nvec            : number of vectors in the batch (0..15)
//   addr, wren, data: RAM address (registered), write enable, write data
//   q               : RAM read data, valid RD_LAT cycles after addr
module dct8_engine
  import dct_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1,
  parameter int SHIFT  = 0,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rstart,
  input  logic [ADDR_W-1:0] wstart,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W-1:0] vec_step,
  input  logic [3:0]        nvec,
  output logic [ADDR_W-1:0] addr,
  output logic              wren,
  output logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] q
);

  // READ cycle indices: first capture, last address step, last cycle.
  localparam logic [3:0] LOAD_FIRST = 4'(RD_LAT);
  localparam logic [3:0] LAST_PT    = 4'(NPTS - 1);
  localparam logic [3:0] READ_LAST  = 4'(NPTS + RD_LAT - 1);

  state_e              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic [3:0]          vcnt, vcnt_n;
  logic [3:0]          vtotal, vtotal_n;
  logic [ADDR_W-1:0]   rbase, rbase_n;
  logic [ADDR_W-1:0]   wbase, wbase_n;
  logic [ADDR_W-1:0]   step, step_n;
  logic [ADDR_W-1:0]   vstep, vstep_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                wren_n;
  logic                busy_n;
  logic                done_n;
  bf_op_e              op;
  logic signed [DATA_W+2:0] bf_out;

  function automatic logic [DATA_W-1:0] conv(input logic signed [DATA_W+2:0] y);
    logic signed [63:0] r;
    r = sat_shift(64'(y), SHIFT, SAT != 0, DATA_W);
    return r[DATA_W-1:0];
  endfunction

  dct8_butterfly #(
    .DATA_W(DATA_W)
  ) u_bf (
    .clk  (clk),
    .reset(reset),
    .op   (op),
    .din  ($signed(q)),
    .dout (bf_out)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    vcnt_n   = vcnt;
    vtotal_n = vtotal;
    rbase_n  = rbase;
    wbase_n  = wbase;
    step_n   = step;
    vstep_n  = vstep;
    addr_n   = addr;
    wren_n   = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
    op       = BF_HOLD;
    case (state)
      IDLE: begin
        if (start) begin
          rbase_n  = rstart;
          wbase_n  = wstart;
          step_n   = stride;
          vstep_n  = vec_step;
          vtotal_n = nvec;
          cnt_n    = '0;
          vcnt_n   = '0;
          // An empty batch skips straight to the done pulse, never busy.
          if (nvec == 4'd0) begin
            state_n = DONE;
          end else begin
            state_n = READ;
            busy_n  = 1'b1;
            addr_n  = rstart;
          end
        end
      end
      // Addresses run ahead of captures by RD_LAT cycles.
      READ: begin
        if (cnt >= LOAD_FIRST) begin
          op = BF_LOAD;
        end
        if (cnt < LAST_PT) begin
          addr_n = addr + step;
        end
        if (cnt == READ_LAST) begin
          state_n = S1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S1: begin
        op      = BF_S1;
        state_n = S2;
      end
      S2: begin
        op      = BF_S2;
        state_n = S3;
      end
      // Results land in the butterfly at the end of S3; the first write
      // cycle presents result 0 straight from register 0.
      S3: begin
        op      = BF_S3;
        state_n = WRITE;
        wren_n  = 1'b1;
        addr_n  = wbase;
        cnt_n   = '0;
      end
      WRITE: begin
        op = BF_SHIFT;
        if (cnt == LAST_PT) begin
          vcnt_n  = vcnt + 4'd1;
          rbase_n = rbase + vstep;
          wbase_n = wbase + vstep;
          if (vcnt + 4'd1 == vtotal) begin
            state_n = DONE;
          end else begin
            state_n = READ;
            addr_n  = rbase + vstep;
            cnt_n   = '0;
          end
        end else begin
          wren_n = 1'b1;
          addr_n = addr + step;
          cnt_n  = cnt + 4'd1;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      vcnt   <= '0;
      vtotal <= '0;
      rbase  <= '0;
      wbase  <= '0;
      step   <= '0;
      vstep  <= '0;
      addr   <= '0;
      wren   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      vcnt   <= vcnt_n;
      vtotal <= vtotal_n;
      rbase  <= rbase_n;
      wbase  <= wbase_n;
      step   <= step_n;
      vstep  <= vstep_n;
      addr   <= addr_n;
      wren   <= wren_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Write data is only driven during write cycles; zero elsewhere.
  assign data = wren ? conv(bf_out) : '0;

endmodule

// File: doc/dct8_engine.md
Name: dct8_engine

Overview:
- Parametrised successor to the existing single-vector 1-D approximate DCT unit. Same 8-point butterfly network.
- Adds:
  - configurable sample width, address width and RAM read latency;
  - output scaling shift with optional saturation;
  - batch mode: one start processes up to 15 vectors, so a full 8x8 row or column pass runs from a single command.
- Sits between the MPEG2 transform controller and the single-port block RAM. Owns the RAM port while busy.

Parameters:
- DATA_W, 16, sample width (two's complement) of RAM words.
- ADDR_W, 6, RAM address width; all address arithmetic wraps modulo 2^ADDR_W.
- RD_LAT, 1, cycles from addr presented to q valid (1..3).
- SHIFT, 0, arithmetic right shift applied to each result before writeback (0..3).
- SAT, 1, 1 = saturate results to DATA_W signed range; 0 = truncate (wrap).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last write of the batch.
- rstart  in  ADDR_W  first read address of vector 0.
- wstart  in  ADDR_W  first write address of vector 0.
- stride  in  ADDR_W  address step between samples within a vector.
- vec_step  in  ADDR_W  step added to both rstart and wstart for each following vector.
- nvec  in  4  number of vectors to process (0..15).
- addr  out  ADDR_W  RAM address (registered).
- wren  out  1  RAM write enable.
- data  out  DATA_W  RAM write data.
- q  in  DATA_W  RAM read data.

Behaviour:
- Reset (async):
  - All regs clear: state=IDLE; addr=0, wren=0, data=0, busy=0, done=0; sample regs=0.
  - Reset mid-batch aborts immediately with no further write. Reset mid-write deasserts wren at once.
- Command accept:
  - IDLE + start: latch rstart, wstart, stride, vec_step and nvec; assert busy next cycle. Later input changes are ignored.
  - start while busy is ignored.
  - nvec=0: no RAM access; done pulses 1 cycle after accept; busy stays 0.
- States: IDLE -> READ -> S1 -> S2 -> S3 -> WRITE -> (READ for the next vector | DONE) -> IDLE.
- READ:
  - addr steps rbase, rbase+stride, ... over 8 cycles.
  - Sample i captured from q at READ cycle i+RD_LAT.
  - Lasts 8+RD_LAT cycles; wren=0 throughout.
- Arithmetic: internal width DATA_W+3 (sign-extended inputs, no overflow possible).
  - S1: a0=x0+x7, a1=x1+x6, a2=x2+x5, a3=x3+x4, a4=x4-x3, a5=x5-x2, a6=x6-x1, a7=x7-x0.
  - S2: b0=a0+a3, b1=a1+a2, b2=a2-a1, b3=a3-a0, b4..b7=a4..a7.
  - S3: y0=b0+b1, y1=-(b6+b7), y2=-b3, y3=b5, y4=b0-b1, y5=b6-b7, y6=b2, y7=b4.
  - Output conversion: r = y >>> SHIFT, then either clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] (SAT=1) or take the low DATA_W bits (SAT=0).
- WRITE:
  - 8 cycles; wren=1; addr = wbase + k*stride; data = r_k for k=0..7.
- Vector advance:
  - After WRITE: rbase += vec_step, wbase += vec_step, vector count++.
  - If count == nvec, go to DONE; else back to READ.
- DONE: done=1 for one cycle, busy=0, back to IDLE.
- Timing:
  - Per-vector cost is 19+RD_LAT cycles.
  - done asserts nvec*(19+RD_LAT)+1 cycles after the accept edge.
- Outputs outside WRITE: wren=0, data=0.
- Wrap: address overflow past 2^ADDR_W-1 wraps silently; no error flag.

Decomposition:
- Shared package dct_pkg holds:
  - the state enum (IDLE, READ, S1, S2, S3, WRITE, DONE);
  - constant NPTS=8;
  - a function sat_shift(value, SHIFT, SAT) returning DATA_W bits.
- One sub-module, dct8_butterfly:
  - register-stage datapath implementing S1..S3 on 8 DATA_W+3 regs;
  - stage-select input from the FSM.
- Address/batch FSM stays in dct8_engine.

Test Plan:
- Ramp: RAM[0..7]=0..7, nvec=1, stride=1, rstart=0, wstart=8 -> RAM[8..15]=28,-12,0,3,0,-2,0,1. done exactly 21 cycles after accept (RD_LAT=1).
- Saturation: all inputs 0x7FFF, SAT=1 -> y0=0x7FFF, others 0. Repeat with SAT=0 -> y0=0xFFF8 (low 16 bits of 262136).
- Shift instance SHIFT=3, ramp input -> 3,-2,0,0,0,-1,0,0.
- Batch: 8x8 block, nvec=8, stride=1, vec_step=8 (rows), then a second command with stride=8, vec_step=1 (columns) -> matches golden 2-D model. Each done at 161 cycles; busy continuous during each batch.
- Boundaries:
  - rstart=62, stride=1 -> read addresses 62,63,0..5.
  - nvec=0 -> done after 1 cycle, wren never asserted.
  - start pulsed while busy -> no effect.
- Reset asserted during WRITE cycle 3 -> wren falls immediately. Only 3 words written; state IDLE; busy=0; next start works normally.
